// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - opcode, state, class and strobe definitions for the Mini-SRC control unit
package control_unit_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_SHRA = 5'b01010;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPC_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPC_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b10000;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPC_W-1:0] OP_BR   = 5'b10011;
  localparam logic [OPC_W-1:0] OP_JR   = 5'b10100;
  localparam logic [OPC_W-1:0] OP_JAL  = 5'b10101;
  localparam logic [OPC_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OPC_W-1:0] OP_OUT  = 5'b10111;
  localparam logic [OPC_W-1:0] OP_MFHI = 5'b11000;
  localparam logic [OPC_W-1:0] OP_MFLO = 5'b11001;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_t;

  typedef enum logic [4:0] {
    CL_ALU3, CL_IMM, CL_UNARY, CL_MULDIV, CL_LD, CL_LDI, CL_ST, CL_BR, CL_JR,
    CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT, CL_ILL
  } class_t;

  typedef struct packed {
    logic pcout, mdrout, zhighout, zlowout, hiout, loout, inportout, cout, baout;
    logic marin, mdrin, irin, yin, zin, pcin, hiin, loin, outportin, conin, r15in;
    logic gra, grb, grc, rin, rout;
    logic incpc, read, write;
    logic [OPC_W-1:0] opcode;
  } ctrl_t;

  // Final execute step of each class; Stop is honoured only there
  function automatic state_t last_step(input class_t c);
    case (c)
      CL_ALU3, CL_IMM, CL_LDI: last_step = ST_T5;
      CL_UNARY, CL_JAL:        last_step = ST_T4;
      CL_MULDIV, CL_BR:        last_step = ST_T6;
      CL_LD, CL_ST:            last_step = ST_T7;
      default:                 last_step = ST_T3;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_instr_class.sv
// rtl/control_unit_instr_class.sv - combinational opcode to instruction-class map
import control_unit_pkg::*;

module control_unit_instr_class (
  input  logic [OPC_W-1:0] i_op,
  output class_t           o_class
);

  // Each opcode selects the step sequence it runs; unknown codes report CL_ILL
  always_comb begin
    o_class = CL_ILL;
    case (i_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
      OP_SHR, OP_SHRA, OP_SHL:   o_class = CL_ALU3;
      OP_ADDI, OP_ANDI, OP_ORI:  o_class = CL_IMM;
      OP_NEG, OP_NOT:            o_class = CL_UNARY;
      OP_MUL, OP_DIV:            o_class = CL_MULDIV;
      OP_LD:                     o_class = CL_LD;
      OP_LDI:                    o_class = CL_LDI;
      OP_ST:                     o_class = CL_ST;
      OP_BR:                     o_class = CL_BR;
      OP_JR:                     o_class = CL_JR;
      OP_JAL:                    o_class = CL_JAL;
      OP_IN:                     o_class = CL_IN;
      OP_OUT:                    o_class = CL_OUT;
      OP_MFHI:                   o_class = CL_MFHI;
      OP_MFLO:                   o_class = CL_MFLO;
      OP_NOP:                    o_class = CL_NOP;
      OP_HALT:                   o_class = CL_HALT;
      default:                   o_class = CL_ILL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - Mini-SRC hardwired Moore sequencer; CTRL_MEM_WAIT_EN adds memory wait states
import control_unit_pkg::*;

module control_unit #(
  parameter int IR_W     = 32,
  parameter bit HALT_ILL = 1'b0
) (
  input  logic            i_clock,
  input  logic            i_clear,
  input  logic [IR_W-1:0] i_ir,
  input  logic            i_con,
  input  logic            i_stop,
`ifdef CTRL_MEM_WAIT_EN
  input  logic            i_mem_ready,
`endif
  output logic            o_pcout,
  output logic            o_mdrout,
  output logic            o_zhighout,
  output logic            o_zlowout,
  output logic            o_hiout,
  output logic            o_loout,
  output logic            o_inportout,
  output logic            o_cout,
  output logic            o_baout,
  output logic            o_marin,
  output logic            o_mdrin,
  output logic            o_irin,
  output logic            o_yin,
  output logic            o_zin,
  output logic            o_pcin,
  output logic            o_hiin,
  output logic            o_loin,
  output logic            o_outportin,
  output logic            o_conin,
  output logic            o_r15in,
  output logic            o_gra,
  output logic            o_grb,
  output logic            o_grc,
  output logic            o_rin,
  output logic            o_rout,
  output logic            o_incpc,
  output logic            o_read,
  output logic            o_write,
  output logic [OPC_W-1:0] o_opcode,
  output logic            o_run
);

  state_t           r_state;
  class_t           r_class;
  logic [OPC_W-1:0] r_op;

  logic [OPC_W-1:0] w_live_op;
  class_t           w_live_class;
  class_t           w_class;
  logic [OPC_W-1:0] w_op;
  logic             w_halt_now;
  logic             w_mem_ready;
  logic             w_hold;
  ctrl_t            w_ctrl;
  ctrl_t            w_out;
  logic             w_unused_ir;

  assign w_live_op   = i_ir[IR_W-1 -: OPC_W];
  assign w_unused_ir = ^i_ir[IR_W-OPC_W-1:0];

  control_unit_instr_class u_instr_class (
    .i_op    (w_live_op),
    .o_class (w_live_class)
  );

  // IR is loaded on the T2->T3 edge, so T3 decodes the live IR and later steps use the copy captured at T3
  assign w_class = (r_state == ST_T3) ? w_live_class : r_class;
  assign w_op    = (r_state == ST_T3) ? w_live_op    : r_op;

  // A halt (or an illegal opcode when HALT_ILL is set) spends its T3 already stopped
  assign w_halt_now = (w_class == CL_HALT) || ((w_class == CL_ILL) && HALT_ILL);

`ifdef CTRL_MEM_WAIT_EN
  assign w_mem_ready = i_mem_ready;
`else
  assign w_mem_ready = 1'b1;
`endif

  assign w_hold = !w_mem_ready &&
                  (((r_state == ST_T6) && (w_class == CL_LD)) ||
                   ((r_state == ST_T7) && (w_class == CL_ST)));

  // Sequencer: state register plus class/opcode capture at T3; clear overrides everything
  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_state <= ST_RST;
      r_class <= CL_NOP;
      r_op    <= '0;
    end else begin
      if (r_state == ST_T3) begin
        r_class <= w_live_class;
        r_op    <= w_live_op;
      end
      case (r_state)
        ST_RST:  r_state <= ST_T0;
        ST_T0:   r_state <= ST_T1;
        ST_T1:   r_state <= w_mem_ready ? ST_T2 : ST_T1;
        ST_T2:   r_state <= ST_T3;
        ST_HALT: r_state <= ST_HALT;
        default: begin
          if ((r_state == ST_T3) && w_halt_now) begin
            r_state <= ST_HALT;
          end else if (w_hold) begin
            r_state <= r_state;
          end else if (r_state == last_step(w_class)) begin
            r_state <= i_stop ? ST_HALT : ST_T0;
          end else begin
            r_state <= state_t'(r_state + 4'd1);
          end
        end
      endcase
    end
  end

  // Strobe decode on {state, class}; only the br T6 PCin looks at an input (CON)
  always_comb begin
    w_ctrl = '0;
    case (r_state)
      ST_T0: begin
        w_ctrl.pcout = 1'b1; w_ctrl.marin = 1'b1; w_ctrl.incpc = 1'b1; w_ctrl.zin = 1'b1;
      end
      ST_T1: begin
        w_ctrl.zlowout = 1'b1; w_ctrl.pcin = 1'b1; w_ctrl.read = 1'b1; w_ctrl.mdrin = 1'b1;
      end
      ST_T2: begin
        w_ctrl.mdrout = 1'b1; w_ctrl.irin = 1'b1;
      end
      ST_T3: begin
        case (w_class)
          CL_ALU3, CL_IMM: begin w_ctrl.grb = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.yin = 1'b1; end
          CL_UNARY: begin
            w_ctrl.grb = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.zin = 1'b1; w_ctrl.opcode = w_op;
          end
          CL_MULDIV: begin w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.yin = 1'b1; end
          CL_LD, CL_LDI, CL_ST: begin w_ctrl.grb = 1'b1; w_ctrl.baout = 1'b1; w_ctrl.yin = 1'b1; end
          CL_BR:   begin w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.conin = 1'b1; end
          CL_JR:   begin w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.pcin = 1'b1; end
          CL_JAL:  begin w_ctrl.pcout = 1'b1; w_ctrl.r15in = 1'b1; end
          CL_IN:   begin w_ctrl.inportout = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1; end
          CL_OUT:  begin w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.outportin = 1'b1; end
          CL_MFHI: begin w_ctrl.hiout = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1; end
          CL_MFLO: begin w_ctrl.loout = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1; end
          default: ;
        endcase
      end
      ST_T4: begin
        case (w_class)
          CL_ALU3: begin
            w_ctrl.grc = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.zin = 1'b1; w_ctrl.opcode = w_op;
          end
          CL_IMM:   begin w_ctrl.cout = 1'b1; w_ctrl.zin = 1'b1; w_ctrl.opcode = w_op; end
          CL_UNARY: begin w_ctrl.zlowout = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1; end
          CL_MULDIV: begin
            w_ctrl.grb = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.zin = 1'b1; w_ctrl.opcode = w_op;
          end
          CL_LD, CL_LDI, CL_ST: begin w_ctrl.cout = 1'b1; w_ctrl.zin = 1'b1; w_ctrl.opcode = OP_ADD; end
          CL_BR:   begin w_ctrl.pcout = 1'b1; w_ctrl.yin = 1'b1; end
          CL_JAL:  begin w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.pcin = 1'b1; end
          default: ;
        endcase
      end
      ST_T5: begin
        case (w_class)
          CL_ALU3, CL_IMM, CL_LDI: begin w_ctrl.zlowout = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1; end
          CL_MULDIV:   begin w_ctrl.zlowout = 1'b1; w_ctrl.loin = 1'b1; end
          CL_LD, CL_ST: begin w_ctrl.zlowout = 1'b1; w_ctrl.marin = 1'b1; end
          CL_BR:       begin w_ctrl.cout = 1'b1; w_ctrl.zin = 1'b1; w_ctrl.opcode = OP_ADD; end
          default: ;
        endcase
      end
      ST_T6: begin
        case (w_class)
          CL_MULDIV: begin w_ctrl.zhighout = 1'b1; w_ctrl.hiin = 1'b1; end
          CL_LD:     begin w_ctrl.read = 1'b1; w_ctrl.mdrin = 1'b1; end
          CL_ST:     begin w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.mdrin = 1'b1; end
          CL_BR:     begin w_ctrl.zlowout = 1'b1; w_ctrl.pcin = i_con; end
          default: ;
        endcase
      end
      ST_T7: begin
        case (w_class)
          CL_LD:   begin w_ctrl.mdrout = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1; end
          CL_ST:   w_ctrl.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign w_out = i_clear ? '0 : w_ctrl;

  assign o_pcout     = w_out.pcout;
  assign o_mdrout    = w_out.mdrout;
  assign o_zhighout  = w_out.zhighout;
  assign o_zlowout   = w_out.zlowout;
  assign o_hiout     = w_out.hiout;
  assign o_loout     = w_out.loout;
  assign o_inportout = w_out.inportout;
  assign o_cout      = w_out.cout;
  assign o_baout     = w_out.baout;
  assign o_marin     = w_out.marin;
  assign o_mdrin     = w_out.mdrin;
  assign o_irin      = w_out.irin;
  assign o_yin       = w_out.yin;
  assign o_zin       = w_out.zin;
  assign o_pcin      = w_out.pcin;
  assign o_hiin      = w_out.hiin;
  assign o_loin      = w_out.loin;
  assign o_outportin = w_out.outportin;
  assign o_conin     = w_out.conin;
  assign o_r15in     = w_out.r15in;
  assign o_gra       = w_out.gra;
  assign o_grb       = w_out.grb;
  assign o_grc       = w_out.grc;
  assign o_rin       = w_out.rin;
  assign o_rout      = w_out.rout;
  assign o_incpc     = w_out.incpc;
  assign o_read      = w_out.read;
  assign o_write     = w_out.write;
  assign o_opcode    = w_out.opcode;

  assign o_run = !i_clear && (r_state != ST_RST) && (r_state != ST_HALT) &&
                 !((r_state == ST_T3) && w_halt_now);

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
module tb_control_unit;

  logic clk = 1'b0;
  logic clear, con, stop;
  logic [31:0] ir;
`ifdef CTRL_MEM_WAIT_EN
  logic mem_ready;
`endif
  logic pcout, mdrout, zhighout, zlowout, hiout, loout, inportout, cout, baout;
  logic marin, mdrin, irin, yin, zin, pcin, hiin, loin, outportin, conin, r15in;
  logic gra, grb, grc, rin, rout, incpc, read, write, run;
  logic [4:0] opcode;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [27:0] M_PCOUT = 28'd1 << 0,  M_MDROUT = 28'd1 << 1,  M_ZHIGHOUT = 28'd1 << 2;
  localparam logic [27:0] M_ZLOWOUT = 28'd1 << 3, M_HIOUT = 28'd1 << 4, M_LOOUT = 28'd1 << 5;
  localparam logic [27:0] M_INPORTOUT = 28'd1 << 6, M_COUT = 28'd1 << 7, M_BAOUT = 28'd1 << 8;
  localparam logic [27:0] M_MARIN = 28'd1 << 9, M_MDRIN = 28'd1 << 10, M_IRIN = 28'd1 << 11;
  localparam logic [27:0] M_YIN = 28'd1 << 12, M_ZIN = 28'd1 << 13, M_PCIN = 28'd1 << 14;
  localparam logic [27:0] M_HIIN = 28'd1 << 15, M_LOIN = 28'd1 << 16, M_OUTPORTIN = 28'd1 << 17;
  localparam logic [27:0] M_CONIN = 28'd1 << 18, M_R15IN = 28'd1 << 19, M_GRA = 28'd1 << 20;
  localparam logic [27:0] M_GRB = 28'd1 << 21, M_GRC = 28'd1 << 22, M_RIN = 28'd1 << 23;
  localparam logic [27:0] M_ROUT = 28'd1 << 24, M_INCPC = 28'd1 << 25, M_READ = 28'd1 << 26;
  localparam logic [27:0] M_WRITE = 28'd1 << 27;
  localparam logic [27:0] M_NONE = 28'd0;

  wire [27:0] strb = {write, read, incpc, rout, rin, grc, grb, gra, r15in, conin, outportin,
                      loin, hiin, pcin, zin, yin, irin, mdrin, marin, baout, cout, inportout,
                      loout, hiout, zlowout, zhighout, mdrout, pcout};

  control_unit dut (
    .i_clock(clk), .i_clear(clear), .i_ir(ir), .i_con(con), .i_stop(stop),
`ifdef CTRL_MEM_WAIT_EN
    .i_mem_ready(mem_ready),
`endif
    .o_pcout(pcout), .o_mdrout(mdrout), .o_zhighout(zhighout), .o_zlowout(zlowout),
    .o_hiout(hiout), .o_loout(loout), .o_inportout(inportout), .o_cout(cout), .o_baout(baout),
    .o_marin(marin), .o_mdrin(mdrin), .o_irin(irin), .o_yin(yin), .o_zin(zin), .o_pcin(pcin),
    .o_hiin(hiin), .o_loin(loin), .o_outportin(outportin), .o_conin(conin), .o_r15in(r15in),
    .o_gra(gra), .o_grb(grb), .o_grc(grc), .o_rin(rin), .o_rout(rout), .o_incpc(incpc),
    .o_read(read), .o_write(write), .o_opcode(opcode), .o_run(run)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [27:0] es, input logic [4:0] eo, input logic er);
    logic [33:0] obs_v, exp_v;
    #1;
    obs_v = {run, opcode, strb};
    exp_v = {er, eo, es};
    n_checks++;
    assert (obs_v === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed run=%b opcode=%b strobes=%h, expected run=%b opcode=%b strobes=%h",
             tag, obs_v[33], obs_v[32:28], obs_v[27:0], exp_v[33], exp_v[32:28], exp_v[27:0]);
    end
  endtask

  // Fetch T0-T2 from T0; leaves the bench in T3 with the new IR applied
  task automatic fetch(input logic [31:0] ir_new);
    chk("fetch_t0", M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'b0, 1'b1);
    step();
    chk("fetch_t1", M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 5'b0, 1'b1);
    step();
    chk("fetch_t2", M_MDROUT | M_IRIN, 5'b0, 1'b1);
    step();
    ir = ir_new;
  endtask

  initial begin
    clear = 1'b1; ir = 32'h0; con = 1'b0; stop = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    repeat (3) step();
    chk("clear_held", M_NONE, 5'b0, 1'b0);
    clear = 1'b0;
    chk("rst_state", M_NONE, 5'b0, 1'b0);
    step();

    // and R1,R2,R3
    fetch(32'h28918000);
    chk("and_t3", M_GRB | M_ROUT | M_YIN, 5'b0, 1'b1); step();
    chk("and_t4", M_GRC | M_ROUT | M_ZIN, 5'b00101, 1'b1); step();
    chk("and_t5", M_ZLOWOUT | M_GRA | M_RIN, 5'b0, 1'b1); step();

    // neg R1,R2 with Stop raised on the non-final step only
    fetch(32'h88900000);
    stop = 1'b1;
    chk("neg_t3", M_GRB | M_ROUT | M_ZIN, 5'b10001, 1'b1); step();
    stop = 1'b0;
    chk("neg_t4", M_ZLOWOUT | M_GRA | M_RIN, 5'b0, 1'b1); step();

    // mul
    fetch(32'h80000000);
    chk("mul_t3", M_GRA | M_ROUT | M_YIN, 5'b0, 1'b1); step();
    chk("mul_t4", M_GRB | M_ROUT | M_ZIN, 5'b10000, 1'b1); step();
    chk("mul_t5", M_ZLOWOUT | M_LOIN, 5'b0, 1'b1); step();
    chk("mul_t6", M_ZHIGHOUT | M_HIIN, 5'b0, 1'b1); step();

    // br: T6 PCin follows CON
    fetch(32'h98000000);
    chk("br_t3", M_GRA | M_ROUT | M_CONIN, 5'b0, 1'b1); step();
    chk("br_t4", M_PCOUT | M_YIN, 5'b0, 1'b1); step();
    chk("br_t5", M_COUT | M_ZIN, 5'b00011, 1'b1); step();
    con = 1'b0;
    chk("br_t6_con0", M_ZLOWOUT, 5'b0, 1'b1);
    con = 1'b1;
    chk("br_t6_con1", M_ZLOWOUT | M_PCIN, 5'b0, 1'b1); step();
    con = 1'b0;

    // ld full sequence
    fetch(32'h00800000);
    chk("ld_t3", M_GRB | M_BAOUT | M_YIN, 5'b0, 1'b1); step();
    chk("ld_t4", M_COUT | M_ZIN, 5'b00011, 1'b1); step();
    chk("ld_t5", M_ZLOWOUT | M_MARIN, 5'b0, 1'b1); step();
    chk("ld_t6", M_READ | M_MDRIN, 5'b0, 1'b1); step();
    chk("ld_t7", M_MDROUT | M_GRA | M_RIN, 5'b0, 1'b1); step();

    // st
    fetch(32'h10800000);
    chk("st_t3", M_GRB | M_BAOUT | M_YIN, 5'b0, 1'b1); step();
    chk("st_t4", M_COUT | M_ZIN, 5'b00011, 1'b1); step();
    chk("st_t5", M_ZLOWOUT | M_MARIN, 5'b0, 1'b1); step();
    chk("st_t6", M_GRA | M_ROUT | M_MDRIN, 5'b0, 1'b1); step();
    chk("st_t7", M_WRITE, 5'b0, 1'b1); step();

    // jal
    fetch(32'hA8000000);
    chk("jal_t3", M_PCOUT | M_R15IN, 5'b0, 1'b1); step();
    chk("jal_t4", M_GRA | M_ROUT | M_PCIN, 5'b0, 1'b1); step();

    // illegal opcode executes as nop by default
    fetch(32'hE0000000);
    chk("ill_t3", M_NONE, 5'b0, 1'b1); step();

    // ld abandoned by clear in T5
    fetch(32'h00800000);
    chk("ldc_t3", M_GRB | M_BAOUT | M_YIN, 5'b0, 1'b1); step();
    chk("ldc_t4", M_COUT | M_ZIN, 5'b00011, 1'b1); step();
    clear = 1'b1;
    chk("ldc_t5_clear", M_NONE, 5'b0, 1'b0); step();
    clear = 1'b0;
    chk("ldc_rst", M_NONE, 5'b0, 1'b0); step();

    // nop with Stop on its final step halts
    fetch(32'hD0000000);
    stop = 1'b1;
    chk("nop_t3", M_NONE, 5'b0, 1'b1); step();
    stop = 1'b0;
    chk("stop_halt", M_NONE, 5'b0, 1'b0);
    clear = 1'b1; step();
    clear = 1'b0;
    chk("stop_rst", M_NONE, 5'b0, 1'b0); step();

`ifdef CTRL_MEM_WAIT_EN
    // T1 held for three extra clocks while memory is not ready
    chk("wait_t0", M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'b0, 1'b1); step();
    mem_ready = 1'b0;
    chk("wait_t1", M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 5'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_t1_hold", M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 5'b0, 1'b1);
    end
    mem_ready = 1'b1; step();
    chk("wait_t2", M_MDROUT | M_IRIN, 5'b0, 1'b1); step();
    ir = 32'hD0000000;
    chk("wait_nop_t3", M_NONE, 5'b0, 1'b1); step();
`endif

    // halt: stopped from T3 onwards until clear
    fetch(32'hD8000000);
    chk("halt_t3", M_NONE, 5'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("halt_hold", M_NONE, 5'b0, 1'b0);
    end
    clear = 1'b1; step();
    clear = 1'b0;
    chk("halt_rst", M_NONE, 5'b0, 1'b0); step();
    chk("halt_restart_t0", M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
